obi_data_router: RTL and testbench
==================================

// Module: obi_data_router
// PURPOSE
//  Routes the core's single OBI-style data port (req/gnt/rvalid) to either the data-memory
//  BFM or the peripheral-memory bridge, decoding on the request address.
//  Sits between riscv32i and the Dmem/Pmem targets inside riscv32i_wrap.
//  Keeps responses in request order: tracks outstanding transactions and stalls any
//  target switch until the other target has drained.
//  Flags protocol violations with a sticky error bit.
// PARAMETERS
//  PMEM_BASE        32'h0000_8000  first byte address routed to the peripheral target
//  PMEM_SIZE        32'h0000_1000  byte span of the peripheral window (non-zero)
//  OUTSTANDING_MAX  8              max in-flight transactions, 1..255
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous, active-high
//  core_req_i    in   1   request valid from core
//  core_addr_i   in   32  byte address
//  core_we_i     in   1   1 = write
//  core_be_i     in   4   byte enables
//  core_wdata_i  in   32  write data
//  core_gnt_o    out  1   request accepted this cycle
//  core_rvalid_o out  1   response valid
//  core_rdata_o  out  32  response data
//  dmem_*        out/in   req/addr/we/be/wdata out, gnt/rvalid/rdata in (same widths as core_*)
//  pmem_*        out/in   req/addr/we/be/wdata out, gnt/rvalid/rdata in (same widths as core_*)
//  outstanding_o out  8   current in-flight count
//  proto_err_o   out  1   sticky protocol-error flag
// BEHAVIOUR
//  - Reset values: outstanding = 0; cur_tgt = DMEM; proto_err_o = 0;
//    all req/gnt/rvalid outputs = 0; rdata outputs = 0.
//  - Decode (combinational): sel_p = (addr - PMEM_BASE) < PMEM_SIZE, 32-bit unsigned
//    wrap-safe compare; otherwise route to DMEM.
//  - stall = (outstanding == OUTSTANDING_MAX) | (outstanding != 0 & sel_p != cur_tgt).
//  - Request path is combinational, zero added latency.
//  - tgt_req = core_req_i & ~stall & decoded target. addr/we/be/wdata pass unmodified to both targets.
//  - core_gnt_o = gnt of the selected target & its req. A target gnt without our req is ignored.
//  - Core holds req/addr stable until gnt; router never grants while stalled.
//  - On accept (core_gnt_o): cur_tgt <= sel_p.
//  - Response path is combinational: core_rvalid_o = valid of cur_tgt target;
//    core_rdata_o = that target's rdata when valid, else 0.
//  - Counter: +1 on accept, -1 on forwarded rvalid. Both in the same cycle -> unchanged.
//    Never wraps.
//  - proto_err_o is set (stays set until reset) on any of:
//    - rvalid from the non-current target
//    - rvalid while outstanding == 0
//    - dmem and pmem rvalid in the same cycle
//  - An erroneous rvalid is dropped: it is not forwarded and the count is unchanged.
//  - Reset mid-transaction: the count clears next edge and any in-flight responses are
//    abandoned. Any rvalid in the reset cycle is not forwarded.
//  - Target switch latency: the first request to the new target is granted no earlier than
//    the cycle the old target's last rvalid is forwarded. A same-cycle release is allowed
//    (stall is evaluated on the pre-edge count, so in practice it is granted the next cycle).
// TESTING
//  1. Reset, then read 0x2600 with dmem gnt the same cycle, rvalid +3 cycles, rdata 0xDEADBEEF
//     -> core_rvalid_o at +3 with 0xDEADBEEF; outstanding goes 1 then 0.
//  2. Write to 0x8004 (inside window) -> only pmem_req_o asserted, be/wdata unchanged;
//     0x9000 (end+1) goes to dmem; 0x7FFC goes to dmem.
//  3. Three back-to-back dmem reads, then a pmem read -> pmem_req_o held 0 and core_gnt_o 0
//     until the 3rd dmem rvalid; the pmem read is then issued and its rdata returned in order.
//  4. OUTSTANDING_MAX=2, dmem responses withheld -> 3rd request not granted and
//     outstanding_o == 2; one rvalid -> 3rd request granted.
//  5. Inject pmem rvalid while only dmem is outstanding -> proto_err_o = 1 next cycle;
//     core_rvalid_o stays 0 and outstanding is unchanged.
//  6. Assert reset with 2 outstanding -> outstanding_o == 0 and proto_err_o == 0;
//     a fresh read afterwards completes normally.

Source files
------------

// File: rtl/obi_data_router_if.sv
// OBI-style data port bundle: request fields from the initiator, grant and response back.
// A transfer happens on req & gnt; req and its fields stay stable until gnt. rvalid/rdata is a
// single-cycle response with no back-pressure, returned in request order.
interface obi_data_router_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/obi_data_router.sv
// Routes the core data port to the data memory or the peripheral window by address, keeping
// responses in order by refusing a target switch until the other target has drained.
module obi_data_router #(
    parameter logic [31:0] PMEM_BASE       = 32'h0000_8000,
    parameter logic [31:0] PMEM_SIZE       = 32'h0000_1000,
    parameter int unsigned OUTSTANDING_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    obi_data_router_if.slave  core,
    obi_data_router_if.master dmem,
    obi_data_router_if.master pmem,
    output logic [7:0]        outstanding_o,
    output logic              proto_err_o
);
    localparam logic [7:0] CNT_MAX = 8'(OUTSTANDING_MAX);

    typedef enum logic {TGT_DMEM = 1'b0, TGT_PMEM = 1'b1} tgt_e;

    tgt_e        cur_tgt_q, cur_tgt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [31:0] win_off;
    logic        sel_p;
    tgt_e        sel_tgt;
    logic        stall, issue, accept;
    logic        cur_rvalid, other_rvalid, both_rvalid, any_rvalid, bad_rvalid, fwd;
    logic [31:0] cur_rdata;

    // Offset subtraction wraps, so addresses below the base land far above PMEM_SIZE.
    assign win_off = core.addr - PMEM_BASE;
    assign sel_p   = (win_off < PMEM_SIZE);
    assign sel_tgt = sel_p ? TGT_PMEM : TGT_DMEM;

    assign stall = (cnt_q == CNT_MAX) | ((cnt_q != 8'd0) & (sel_tgt != cur_tgt_q));
    assign issue = ~reset & core.req & ~stall;

    assign dmem.req   = issue & ~sel_p;
    assign dmem.addr  = core.addr;
    assign dmem.we    = core.we;
    assign dmem.be    = core.be;
    assign dmem.wdata = core.wdata;

    assign pmem.req   = issue & sel_p;
    assign pmem.addr  = core.addr;
    assign pmem.we    = core.we;
    assign pmem.be    = core.be;
    assign pmem.wdata = core.wdata;

    assign accept   = (dmem.req & dmem.gnt) | (pmem.req & pmem.gnt);
    assign core.gnt = accept;

    assign cur_rvalid   = (cur_tgt_q == TGT_PMEM) ? pmem.rvalid : dmem.rvalid;
    assign other_rvalid = (cur_tgt_q == TGT_PMEM) ? dmem.rvalid : pmem.rvalid;
    assign cur_rdata    = (cur_tgt_q == TGT_PMEM) ? pmem.rdata  : dmem.rdata;
    assign both_rvalid  = dmem.rvalid & pmem.rvalid;
    assign any_rvalid   = dmem.rvalid | pmem.rvalid;
    assign bad_rvalid   = other_rvalid | both_rvalid | (any_rvalid & (cnt_q == 8'd0));

    // Any offending response is swallowed whole, including a coincident legal one.
    assign fwd         = ~reset & cur_rvalid & ~bad_rvalid;
    assign core.rvalid = fwd;
    assign core.rdata  = fwd ? cur_rdata : 32'd0;

    always_comb begin
        cnt_d     = cnt_q;
        cur_tgt_d = cur_tgt_q;
        err_d     = err_q | bad_rvalid;
        if (accept && !fwd)
            cnt_d = cnt_q + 8'd1;
        else if (!accept && fwd)
            cnt_d = cnt_q - 8'd1;
        if (accept)
            cur_tgt_d = sel_tgt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= 8'd0;
            cur_tgt_q <= TGT_DMEM;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cur_tgt_q <= cur_tgt_d;
            err_q     <= err_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign proto_err_o   = err_q;
endmodule

// File: tb/tb_obi_data_router.sv
// Directed bench for obi_data_router: routing table plus multi-cycle ordering, stall,
// error and reset sequences. A second instance runs with a two-deep outstanding limit.
module tb_obi_data_router;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    obi_data_router_if c_if ();
    obi_data_router_if d_if ();
    obi_data_router_if p_if ();
    logic [7:0] outstanding;
    logic       proto_err;

    obi_data_router dut (
        .clk(clk), .reset(reset), .core(c_if), .dmem(d_if), .pmem(p_if),
        .outstanding_o(outstanding), .proto_err_o(proto_err)
    );

    obi_data_router_if c2_if ();
    obi_data_router_if d2_if ();
    obi_data_router_if p2_if ();
    logic [7:0] outstanding2;
    logic       proto_err2;

    obi_data_router #(.OUTSTANDING_MAX(2)) dut2 (
        .clk(clk), .reset(reset), .core(c2_if), .dmem(d2_if), .pmem(p2_if),
        .outstanding_o(outstanding2), .proto_err_o(proto_err2)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        dgnt;
        logic        pgnt;
        logic        exp_dreq;
        logic        exp_preq;
        logic        exp_gnt;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        c_if.req = 0;  c_if.addr = 0;  c_if.we = 0;  c_if.be = 0;  c_if.wdata = 0;
        d_if.gnt = 0;  d_if.rvalid = 0;  d_if.rdata = 0;
        p_if.gnt = 0;  p_if.rvalid = 0;  p_if.rdata = 0;
        c2_if.req = 0; c2_if.addr = 0; c2_if.we = 0; c2_if.be = 0; c2_if.wdata = 0;
        d2_if.gnt = 0; d2_if.rvalid = 0; d2_if.rdata = 0;
        p2_if.gnt = 0; p2_if.rvalid = 0; p2_if.rdata = 0;
    endtask

    task automatic dmem_read_accept(input logic [31:0] a);
        c_if.req = 1; c_if.addr = a; c_if.we = 0; c_if.be = 4'hF; d_if.gnt = 1;
        #1;
        check("rd accept gnt", 32'(c_if.gnt), 32'd1);
        cyc();
        c_if.req = 0; d_if.gnt = 0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_2600, 1'b0, 4'hF, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_8004, 1'b1, 4'h5, 32'hA5A5_1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_8000, 1'b0, 4'h3, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_8FFF, 1'b1, 4'h8, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_9000, 1'b1, 4'hC, 32'h1111_2222, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_7FFC, 1'b0, 4'hF, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_8004, 1'b0, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 32'h0000_2600, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 32'h0000_8004, 1'b0, 4'hF, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        clear_inputs();
        reset = 1;
        cyc();
        cyc();
        // Traffic during reset must neither issue nor forward.
        c_if.req = 1; c_if.addr = 32'h2600; d_if.gnt = 1; d_if.rvalid = 1; d_if.rdata = 32'h77;
        #1;
        check("reset dreq", 32'(d_if.req), 32'd0);
        check("reset gnt", 32'(c_if.gnt), 32'd0);
        check("reset rvalid", 32'(c_if.rvalid), 32'd0);
        check("reset rdata", c_if.rdata, 32'd0);
        cyc();
        check("reset outstanding", 32'(outstanding), 32'd0);
        check("reset proto_err", 32'(proto_err), 32'd0);
        clear_inputs();
        reset = 0;
        cyc();

        // Routing table, no grants that would be accepted.
        for (int i = 0; i < 10; i++) begin
            c_if.req = vecs[i].req; c_if.addr = vecs[i].addr; c_if.we = vecs[i].we;
            c_if.be = vecs[i].be; c_if.wdata = vecs[i].wdata;
            d_if.gnt = vecs[i].dgnt; p_if.gnt = vecs[i].pgnt;
            #1;
            check($sformatf("vec%0d dreq", i), 32'(d_if.req), 32'(vecs[i].exp_dreq));
            check($sformatf("vec%0d preq", i), 32'(p_if.req), 32'(vecs[i].exp_preq));
            check($sformatf("vec%0d gnt", i), 32'(c_if.gnt), 32'(vecs[i].exp_gnt));
            check($sformatf("vec%0d paddr", i), p_if.addr, vecs[i].addr);
            check($sformatf("vec%0d dwdata", i), d_if.wdata, vecs[i].wdata);
            check($sformatf("vec%0d pbe", i), 32'(p_if.be), 32'(vecs[i].be));
            check($sformatf("vec%0d pwe", i), 32'(p_if.we), 32'(vecs[i].we));
            cyc();
        end
        clear_inputs();
        #1;
        check("table outstanding", 32'(outstanding), 32'd0);
        cyc();

        // Single dmem read, response three cycles after accept.
        dmem_read_accept(32'h2600);
        check("t1 outstanding 1", 32'(outstanding), 32'd1);
        for (int k = 1; k < 3; k++) begin
            check($sformatf("t1 idle rvalid %0d", k), 32'(c_if.rvalid), 32'd0);
            cyc();
        end
        d_if.rvalid = 1; d_if.rdata = 32'hDEADBEEF;
        #1;
        check("t1 rvalid", 32'(c_if.rvalid), 32'd1);
        check("t1 rdata", c_if.rdata, 32'hDEADBEEF);
        cyc();
        d_if.rvalid = 0;
        check("t1 outstanding 0", 32'(outstanding), 32'd0);

        // Three dmem reads then a pmem read held off until the dmem side drains.
        dmem_read_accept(32'h100);
        dmem_read_accept(32'h104);
        dmem_read_accept(32'h108);
        check("t3 outstanding 3", 32'(outstanding), 32'd3);
        c_if.req = 1; c_if.addr = 32'h8000; p_if.gnt = 1;
        for (int k = 0; k < 3; k++) begin
            d_if.rvalid = 1; d_if.rdata = 32'hA0 + 32'(k);
            #1;
            check($sformatf("t3 stall preq %0d", k), 32'(p_if.req), 32'd0);
            check($sformatf("t3 stall gnt %0d", k), 32'(c_if.gnt), 32'd0);
            check($sformatf("t3 drsp %0d", k), c_if.rdata, 32'hA0 + 32'(k));
            cyc();
        end
        d_if.rvalid = 0;
        #1;
        check("t3 drained", 32'(outstanding), 32'd0);
        check("t3 preq", 32'(p_if.req), 32'd1);
        check("t3 pgnt", 32'(c_if.gnt), 32'd1);
        cyc();
        c_if.req = 0; p_if.gnt = 0;
        p_if.rvalid = 1; p_if.rdata = 32'hCAFE0001;
        #1;
        check("t3 prvalid", 32'(c_if.rvalid), 32'd1);
        check("t3 prdata", c_if.rdata, 32'hCAFE0001);
        cyc();
        p_if.rvalid = 0;
        check("t3 outstanding 0", 32'(outstanding), 32'd0);

        // Outstanding limit of two on the second instance.
        for (int k = 0; k < 2; k++) begin
            c2_if.req = 1; c2_if.addr = 32'h300 + 32'(4 * k); c2_if.be = 4'hF; d2_if.gnt = 1;
            cyc();
        end
        c2_if.addr = 32'h308;
        #1;
        check("t4 outstanding 2", 32'(outstanding2), 32'd2);
        check("t4 full dreq", 32'(d2_if.req), 32'd0);
        check("t4 full gnt", 32'(c2_if.gnt), 32'd0);
        d2_if.rvalid = 1; d2_if.rdata = 32'h3;
        #1;
        check("t4 rsp while full gnt", 32'(c2_if.gnt), 32'd0);
        cyc();
        d2_if.rvalid = 0;
        #1;
        check("t4 after rsp outstanding", 32'(outstanding2), 32'd1);
        check("t4 third gnt", 32'(c2_if.gnt), 32'd1);
        cyc();
        c2_if.req = 0; d2_if.gnt = 0;
        check("t4 outstanding 2 again", 32'(outstanding2), 32'd2);

        // Stray pmem response while only dmem is outstanding.
        dmem_read_accept(32'h200);
        p_if.rvalid = 1; p_if.rdata = 32'h55;
        #1;
        check("t5 rvalid dropped", 32'(c_if.rvalid), 32'd0);
        check("t5 rdata zero", c_if.rdata, 32'd0);
        cyc();
        p_if.rvalid = 0;
        check("t5 proto_err", 32'(proto_err), 32'd1);
        check("t5 outstanding kept", 32'(outstanding), 32'd1);
        d_if.rvalid = 1; d_if.rdata = 32'h66;
        #1;
        check("t5 drain rdata", c_if.rdata, 32'h66);
        cyc();
        d_if.rvalid = 0;
        check("t5 sticky", 32'(proto_err), 32'd1);
        check("t5 outstanding 0", 32'(outstanding), 32'd0);

        // Reset with two in flight, then a fresh read.
        dmem_read_accept(32'h400);
        dmem_read_accept(32'h404);
        check("t6 outstanding 2", 32'(outstanding), 32'd2);
        reset = 1; d_if.rvalid = 1; d_if.rdata = 32'h99;
        #1;
        check("t6 reset rvalid", 32'(c_if.rvalid), 32'd0);
        cyc();
        reset = 0; d_if.rvalid = 0;
        check("t6 outstanding cleared", 32'(outstanding), 32'd0);
        check("t6 proto_err cleared", 32'(proto_err), 32'd0);
        dmem_read_accept(32'h2600);
        d_if.rvalid = 1; d_if.rdata = 32'h12345678;
        #1;
        check("t6 fresh rdata", c_if.rdata, 32'h12345678);
        cyc();
        d_if.rvalid = 0;
        check("t6 fresh outstanding", 32'(outstanding), 32'd0);

        // Response with nothing outstanding, then simultaneous responses.
        d_if.rvalid = 1; d_if.rdata = 32'h1;
        #1;
        check("idle rvalid dropped", 32'(c_if.rvalid), 32'd0);
        cyc();
        d_if.rvalid = 0;
        check("idle rvalid err", 32'(proto_err), 32'd1);
        check("idle rvalid count", 32'(outstanding), 32'd0);
        reset = 1;
        cyc();
        reset = 0;
        dmem_read_accept(32'h500);
        d_if.rvalid = 1; p_if.rvalid = 1;
        #1;
        check("both rvalid dropped", 32'(c_if.rvalid), 32'd0);
        cyc();
        d_if.rvalid = 0; p_if.rvalid = 0;
        check("both rvalid err", 32'(proto_err), 32'd1);
        check("both rvalid count", 32'(outstanding), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
